// File: rtl/bus_arbiter.sv
// Round-robin arbiter and packet sequencer for the shared serial bus:
// grants one node, times the packet, waits for the acknowledge, then holds an idle gap.
module bus_arbiter #(
    parameter int NUM_NODES   = 4,
    parameter int PACKET_BITS = 80,
    parameter int ACK_TIMEOUT = 8,
    parameter int GAP_CYCLES  = 2,
    localparam int OW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
    localparam int BW = $clog2(PACKET_BITS),
    localparam int TW = $clog2(ACK_TIMEOUT + 1),
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_NODES-1:0] req,
    input  logic                 main_bus,
    output logic [NUM_NODES-1:0] grant,
    output logic                 is_free,
    output logic [OW-1:0]        owner,
    output logic                 busy,
    output logic                 done_ok,
    output logic                 done_err,
    output logic [BW-1:0]        bit_cnt
);

    typedef enum logic [1:0] {IDLE, XMIT, ACK_WAIT, GAP} state_t;

    state_t               state_q, state_d;
    logic [NUM_NODES-1:0] grant_q, grant_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        ptr_q, ptr_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 done_ok_q, done_ok_d;
    logic                 done_err_q, done_err_d;

    // Rotate requests so the pointer lands on bit 0, then take the lowest set bit.
    logic [2*NUM_NODES-1:0] req_dbl;
    logic [NUM_NODES-1:0]   req_rot;
    logic [OW-1:0]          rot_off;
    logic [OW:0]            win_sum;
    logic [OW-1:0]          winner;
    logic                   any_req;

    assign req_dbl = {req, req} >> ptr_q;
    assign req_rot = req_dbl[NUM_NODES-1:0];
    assign any_req = |req;

    always_comb begin
        rot_off = '0;
        for (int k = NUM_NODES - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rot_off = OW'(k);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, rot_off};
        if (win_sum >= (OW+1)'(NUM_NODES)) begin
            win_sum = win_sum - (OW+1)'(NUM_NODES);
        end
        winner = win_sum[OW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        done_ok_d  = 1'b0;
        done_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = XMIT;
                    grant_d   = NUM_NODES'(1) << winner;
                    owner_d   = winner;
                    ptr_d     = (winner == OW'(NUM_NODES - 1)) ? '0 : winner + OW'(1);
                    bit_cnt_d = BW'(PACKET_BITS - 1);
                end
            end
            XMIT: begin
                // A sender dropping its request mid-packet wins over the final bit.
                if (!req[owner_q]) begin
                    state_d    = GAP;
                    grant_d    = '0;
                    bit_cnt_d  = '0;
                    gap_d      = GW'(GAP_CYCLES - 1);
                    done_err_d = 1'b1;
                end else if (bit_cnt_q == '0) begin
                    state_d = ACK_WAIT;
                    grant_d = '0;
                    timer_d = TW'(ACK_TIMEOUT);
                end else begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end
            end
            ACK_WAIT: begin
                if (main_bus) begin
                    state_d   = GAP;
                    gap_d     = GW'(GAP_CYCLES - 1);
                    done_ok_d = 1'b1;
                end else if (timer_q <= TW'(1)) begin
                    state_d    = GAP;
                    gap_d      = GW'(GAP_CYCLES - 1);
                    done_err_d = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            gap_q      <= '0;
            done_ok_q  <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            done_ok_q  <= done_ok_d;
            done_err_q <= done_err_d;
        end
    end

    assign grant    = grant_q;
    assign is_free  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;
    assign done_ok  = done_ok_q;
    assign done_err = done_err_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter and sequencer for the shared single-bit serial bus (main_bus) and its is_free line used by all nodes.
- Grants the bus to one requesting node at a time (round-robin) and times the fixed-length packet.
- Watches for the receiver acknowledge, reports the outcome, and enforces an inter-packet gap before the bus is freed again.

Parameters:
- NUM_NODES, 4, number of requesting nodes (2..16).
- PACKET_BITS, 80, serial packet length in bits (start, addresses, size, 64-bit data, CRC, end).
- ACK_TIMEOUT, 8, maximum cycles to wait for the receiver acknowledge after the last packet bit.
- GAP_CYCLES, 2, idle cycles forced after every transaction before is_free rises (>=1).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_NODES  per-node bus request; level, held until grant and through transmission.
- main_bus  input  1  sampled serial bus value; a receiver acknowledges by driving 1.
- grant  output  NUM_NODES  one-hot bus grant; all zero when no owner.
- is_free  output  1  1 = bus free, nodes may request and begin.
- owner  output  clog2(NUM_NODES)  index of current or last granted node.
- busy  output  1  1 from grant through end of gap.
- done_ok  output  1  one-cycle pulse: acknowledge seen.
- done_err  output  1  one-cycle pulse: ack timeout or sender abort.
- bit_cnt  output  clog2(PACKET_BITS)  bits remaining in XMIT (debug/monitor).

Behaviour:
- Reset (async, any state): state=IDLE, grant=0, is_free=1, owner=0, busy=0, done_ok=0, done_err=0, bit_cnt=0, round-robin pointer=0.
- States: IDLE, XMIT, ACK_WAIT, GAP.
- IDLE: is_free=1, grant=0. If any req bit set at an edge, on that edge:
  - pick the winner: first set bit at or after the pointer, wrapping modulo NUM_NODES;
  - set grant[winner]=1, owner=winner, is_free=0, busy=1, bit_cnt=PACKET_BITS-1, pointer=(winner+1) mod NUM_NODES;
  - go to XMIT.
- Simultaneous requests: exactly one winner. Losers keep req asserted and compete again after GAP.
- XMIT: lasts exactly PACKET_BITS cycles. bit_cnt decrements each cycle. On the cycle bit_cnt==0, go to ACK_WAIT, clear grant, reset the ack timer to ACK_TIMEOUT.
- Abort: req[owner] deasserted during XMIT -> next edge: grant=0, done_err pulse, go to GAP. The remaining bits are not counted.
- ACK_WAIT: main_bus sampled each cycle.
  - First cycle with main_bus==1: done_ok pulse, go to GAP.
  - Timer reaches 0 with no 1 seen: done_err pulse, go to GAP.
  - Worst case: exactly ACK_TIMEOUT cycles in ACK_WAIT.
- GAP: grant=0, is_free=0 for GAP_CYCLES cycles. Then go to IDLE with is_free=1 and busy=0. Requests are not evaluated until IDLE.
- done_ok and done_err are never asserted together and are high for exactly one cycle.
- Latency: req to grant = 1 cycle from IDLE. Grant to is_free rising (ack on first ACK_WAIT cycle) = PACKET_BITS+1+GAP_CYCLES cycles.
- Pointer wrap: after winner NUM_NODES-1, pointer=0.
- Counter widths: sized for PACKET_BITS-1, ACK_TIMEOUT and GAP_CYCLES. No overflow is possible.
- Reset mid-transaction: returns to IDLE immediately with no done pulse. The pointer is cleared to 0.

Test Plan:
- Reset: drive reset_n=0 mid-XMIT -> grant=0000, is_free=1, busy=0 asynchronously; after release, req=0010 -> grant=0010 next edge.
- Single sender with ack: req=0001, main_bus=1 on 3rd ACK_WAIT cycle -> grant=0001 for exactly 80 cycles, done_ok one pulse, is_free=1 2 cycles later.
- Round-robin: req=1111 held for 4 transactions, all acked -> owner sequence 0,1,2,3, then 0 again (wrap).
- Ack timeout: req=0100, main_bus held 0 -> after 80 XMIT cycles plus 8 ACK_WAIT cycles, done_err pulse, done_ok stays 0, is_free=1 after GAP.
- Abort: req=1000, deassert req[3] when bit_cnt=40 -> grant drops next edge, done_err pulse, bus free 2 cycles later.
- Contention after gap: req=0011 with node 0 active, node 1 held -> owner=1 granted the first IDLE edge after GAP, never during GAP.
